// File: rtl/dds_phase_ctrl_pkg.sv
// Shared types for the DDS phase-accumulator front end.
package dds_phase_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/dds_phase_ctrl_if.sv
// Tuning-word handshake plus waveform ROM read port, seen from the phase controller.
interface dds_phase_ctrl_if #(
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8
);
  logic [PHASE_WIDTH-1:0] fword;
  logic                   fword_valid;
  logic                   fword_ready;
  logic [ADDR_WIDTH-1:0]  rom_addr;
  logic [DATA_WIDTH-1:0]  rom_q;

  modport master (
    input  fword, fword_valid, rom_q,
    output fword_ready, rom_addr
  );

  modport slave (
    output fword, fword_valid, rom_q,
    input  fword_ready, rom_addr
  );
endinterface

// File: rtl/dds_phase_acc.sv
// Phase accumulator with carry-out marker and phase-continuous tuning-word update.
module dds_phase_acc #(
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run_i,
  input  logic                   clr_i,
  input  logic [PHASE_WIDTH-1:0] fword_i,
  input  logic                   fword_valid_i,
  output logic                   fword_ready_o,
  output logic [ADDR_WIDTH-1:0]  acc_msb_o,
  output logic                   wrap_o
);

  logic [PHASE_WIDTH-1:0] acc_q, acc_d;
  logic [PHASE_WIDTH-1:0] cur_q, cur_d;
  logic [PHASE_WIDTH-1:0] pend_q, pend_d;
  logic                   pend_flag_q, pend_flag_d;
  logic                   ready_q, ready_d;
  logic                   wrap_q, wrap_d;
  logic [PHASE_WIDTH:0]   sum;
  logic                   accept;

  always_comb begin
    sum         = {1'b0, acc_q} + {1'b0, cur_q};
    accept      = fword_valid_i & ready_q;
    acc_d       = acc_q;
    cur_d       = cur_q;
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    ready_d     = ready_q;
    wrap_d      = 1'b0;
    if (run_i) begin
      acc_d  = sum[PHASE_WIDTH-1:0];
      wrap_d = sum[PHASE_WIDTH] & ~clr_i;
      // Pending word takes effect only at a period boundary; this accumulate used the old step.
      if (wrap_d && pend_flag_q) begin
        cur_d       = pend_q;
        pend_flag_d = 1'b0;
        ready_d     = 1'b1;
      end
      if (accept) begin
        pend_d      = fword_i;
        pend_flag_d = 1'b1;
        ready_d     = 1'b0;
      end
    end else if (pend_flag_q) begin
      cur_d       = pend_q;
      pend_flag_d = 1'b0;
      ready_d     = 1'b1;
    end else if (accept) begin
      cur_d = fword_i;
    end
    if (clr_i) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cur_q       <= '0;
      pend_q      <= '0;
      pend_flag_q <= 1'b0;
      ready_q     <= 1'b1;
      wrap_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
      ready_q     <= ready_d;
      wrap_q      <= wrap_d;
    end
  end

  assign fword_ready_o = ready_q;
  assign acc_msb_o     = acc_q[PHASE_WIDTH-1 -: ADDR_WIDTH];
  assign wrap_o        = wrap_q;

endmodule

// File: rtl/dds_phase_ctrl.sv
// DDS front end: run/idle control, offset ROM address, valid pipe and sample register.
module dds_phase_ctrl
  import dds_phase_ctrl_pkg::*;
#(
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  phase_clr,
  input  logic [ADDR_WIDTH-1:0] poff,
  dds_phase_ctrl_if.master      bus,
  output logic [DATA_WIDTH-1:0] wave_out,
  output logic                  wave_valid,
  output logic                  wrap
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] rom_addr_q;
  logic                  addr_vld_q;
  logic                  q_vld_q;
  logic                  wave_valid_q;
  logic [DATA_WIDTH-1:0] wave_q;
  logic [ADDR_WIDTH-1:0] acc_msb;
  logic                  run;

  assign run = (state_q == RUN);

  dds_phase_acc #(
    .PHASE_WIDTH(PHASE_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_acc (
    .clk          (clk),
    .rst          (rst),
    .run_i        (run),
    .clr_i        (phase_clr),
    .fword_i      (bus.fword),
    .fword_valid_i(bus.fword_valid),
    .fword_ready_o(bus.fword_ready),
    .acc_msb_o    (acc_msb),
    .wrap_o       (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      addr_vld_q <= 1'b0;
    end else begin
      addr_vld_q <= run;
      unique case (state_q)
        IDLE: begin
          if (en) state_q <= RUN;
        end
        RUN: begin
          // Address uses the pre-update accumulator; offset add wraps in address width.
          rom_addr_q <= acc_msb + poff;
          if (!en) state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_vld_q      <= 1'b0;
      wave_valid_q <= 1'b0;
      wave_q       <= '0;
    end else begin
      q_vld_q      <= addr_vld_q;
      wave_valid_q <= q_vld_q;
      wave_q       <= bus.rom_q;
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign wave_out     = wave_q;
  assign wave_valid   = wave_valid_q;

endmodule

// File: tb/tb_dds_phase_ctrl.sv
// Randomised bench for dds_phase_ctrl with a transaction-level phase/step model.
module tb_dds_phase_ctrl;
  localparam int PW = 16;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          phase_clr = 1'b0;
  logic [AW-1:0] poff = '0;
  logic [DW-1:0] wave_out;
  logic          wave_valid;
  logic          wrap;

  dds_phase_ctrl_if #(.PHASE_WIDTH(PW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dds_phase_ctrl #(.PHASE_WIDTH(PW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .phase_clr (phase_clr),
    .poff      (poff),
    .bus       (bus),
    .wave_out  (wave_out),
    .wave_valid(wave_valid),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [7:0] a);
    return a * 8'd37 + 8'd11;
  endfunction

  // Single-port waveform ROM with one-cycle registered read.
  always @(posedge clk) bus.rom_q <= rom_val(bus.rom_addr);

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {bit vld; bit [7:0] a;} iss_t;

  bit          chk_on = 1'b0;
  bit          m_run;
  int unsigned m_acc;
  int unsigned m_step;
  int unsigned m_pend[$];
  bit [7:0]    m_addr;
  bit          m_wrap;
  bit          m_ready;
  iss_t        m_iss[$];
  bit [7:0]    e_wave;
  bit          e_vld;
  bit          e_wave_chk;

  always @(posedge clk) begin
    int unsigned sum;
    bit          acc_f;
    bit [7:0]    na;
    iss_t        it;
    if (rst) begin
      m_run = 0; m_acc = 0; m_step = 0; m_pend.delete();
      m_addr = 0; m_wrap = 0; m_ready = 1;
      m_iss.delete();
      it.vld = 0; it.a = 0;
      m_iss.push_back(it); m_iss.push_back(it);
      e_wave = 0; e_vld = 0; e_wave_chk = 1;
      chk_on = 1;
    end else begin
      acc_f = bus.fword_valid && m_ready;
      na = m_addr;
      m_wrap = 0;
      if (m_run) begin
        na = 8'((m_acc >> (PW - AW)) + poff);
        sum = m_acc + m_step;
        m_wrap = (sum >= (1 << PW)) && !phase_clr;
        m_acc = sum & ((1 << PW) - 1);
        if (m_wrap && m_pend.size() > 0) m_step = m_pend.pop_front();
        if (acc_f) m_pend.push_back(32'(bus.fword));
      end else if (m_pend.size() > 0) begin
        m_step = m_pend.pop_front();
      end else if (acc_f) begin
        m_step = 32'(bus.fword);
      end
      if (phase_clr) m_acc = 0;
      m_ready = (m_pend.size() == 0);
      it.vld = m_run; it.a = na;
      m_iss.push_back(it);
      m_addr = na;
      it = m_iss.pop_front();
      e_vld = it.vld;
      e_wave = rom_val(it.a);
      e_wave_chk = it.vld;
      m_run = en;
    end
    if (chk_on) begin
      #1;
      check("rom_addr", 32'(bus.rom_addr), 32'(m_addr));
      check("fword_ready", 32'(bus.fword_ready), 32'(m_ready));
      check("wrap", 32'(wrap), 32'(m_wrap));
      check("wave_valid", 32'(wave_valid), 32'(e_vld));
      if (e_wave_chk) check("wave_out", 32'(wave_out), 32'(e_wave));
    end
  end

  task automatic offer(input logic [PW-1:0] w);
    bus.fword = w;
    bus.fword_valid = 1'b1;
    @(negedge clk);
    bus.fword_valid = 1'b0;
  endtask

  initial begin
    bus.fword = '0;
    bus.fword_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_addr", 32'(bus.rom_addr), 32'h0);
    check("rst_ready", 32'(bus.fword_ready), 32'h1);
    check("rst_wvalid", 32'(wave_valid), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_wave", 32'(wave_out), 32'h0);
    rst = 1'b0;

    // Load step in IDLE, then run from acc=0 with no offset.
    offer(16'h0100);
    en = 1'b1;
    repeat (4) @(negedge clk);
    check("t1_addr", 32'(bus.rom_addr), 32'h2);
    check("t1_wvalid", 32'(wave_valid), 32'h1);
    check("t1_wave", 32'(wave_out), 32'(rom_val(8'h0)));
    check("t1_ready", 32'(bus.fword_ready), 32'h1);

    // Offset wraps the address; wrap once per 256 cycles.
    poff = 8'hF0;
    repeat (300) @(negedge clk);

    // Running word change is deferred to the next wrap.
    offer(16'h8000);
    check("t2_ready_drop", 32'(bus.fword_ready), 32'h0);
    repeat (300) @(negedge clk);
    offer(16'h4000);
    check("t2_ready_drop2", 32'(bus.fword_ready), 32'h0);
    repeat (20) @(negedge clk);

    phase_clr = 1'b1;
    @(negedge clk);
    phase_clr = 1'b0;
    check("t4_no_wrap", 32'(wrap), 32'h0);
    repeat (10) @(negedge clk);

    en = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_drained", 32'(wave_valid), 32'h0);
    en = 1'b1;
    repeat (20) @(negedge clk);

    // Reset with a word pending: step returns to zero and the address freezes at poff.
    poff = 8'h00;
    offer(16'h0100);
    for (int i = 0; i < 1000 && !bus.fword_ready; i++) @(negedge clk);
    check("t6_ready_wait", 32'(bus.fword_ready), 32'h1);
    offer(16'h2000);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_addr", 32'(bus.rom_addr), 32'h0);
    check("t6_rst_ready", 32'(bus.fword_ready), 32'h1);
    check("t6_rst_wvalid", 32'(wave_valid), 32'h0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_addr_hold", 32'(bus.rom_addr), 32'h0);
    check("t6_wvalid", 32'(wave_valid), 32'h1);

    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 19) == 0) en = ~en;
      phase_clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) poff = AW'($urandom);
      bus.fword_valid = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: bus.fword = PW'($urandom);
        1: bus.fword = 16'h0100;
        2: bus.fword = 16'h0000;
        default: bus.fword = PW'($urandom_range(1, 16) << 10);
      endcase
      @(negedge clk);
    end
    rst = 1'b0;
    bus.fword_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
